mlp_mem_loader: RTL

- Fills the MLP parameter and input memories from a host word stream, then raises mem_ready to the layer controller.
- The layer controller waits in its Init state until mem_ready is high. This block is the producer of that handshake.
- Writes W1, B1, W2, B2 and the input buffer in a fixed order. Holds mem_ready until the controller releases it.
- Optionally reloads only the input vector, keeping weights and biases already in memory.

---
 rtl/mlp_mem_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mlp_mem_loader.sv
// Streams host words into the MLP W1/B1/W2/B2/input memories in a fixed order,
// then holds mem_ready until the layer controller releases it.
//   state | meaning
//   IDLE  | waiting for load_start
//   LD_W1 | loading layer-1 weights
//   LD_B1 | loading layer-1 biases
//   LD_W2 | loading layer-2 weights
//   LD_B2 | loading layer-2 biases
//   LD_IN | loading the input vector
//   READY | memories complete, mem_ready high
module mlp_mem_loader #(
    parameter int WORD_W = 32,
    parameter int N_W1   = 32,
    parameter int N_B1   = 4,
    parameter int N_W2   = 8,
    parameter int N_B2   = 2,
    parameter int N_IN   = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              inputs_only,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              w1_we,
    output logic              b1_we,
    output logic              w2_we,
    output logic              b2_we,
    output logic              in_we,
    output logic              mem_ready,
    input  logic              mem_release,
    output logic              busy,
    output logic              load_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_W1 = 3'd1,
        LD_B1 = 3'd2,
        LD_W2 = 3'd3,
        LD_B2 = 3'd4,
        LD_IN = 3'd5,
        READY = 3'd6
    } state_t;

    state_t            state, state_next, start_state;
    logic [ADDR_W-1:0] cnt;
    logic              weights_valid;
    logic              sec_last;
    logic              xfer;

    assign s_ready   = (state == LD_W1) || (state == LD_B1) || (state == LD_W2) ||
                       (state == LD_B2) || (state == LD_IN);
    assign busy      = s_ready;
    assign mem_ready = (state == READY);
    assign xfer      = s_valid && s_ready;

    // An inputs-only request before any weights exist is promoted to a full load.
    assign start_state = (inputs_only && weights_valid) ? LD_IN : LD_W1;

    always_comb begin
        state_next = state;
        sec_last   = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) state_next = start_state;
            end
            LD_W1: begin
                sec_last = (cnt == ADDR_W'(N_W1 - 1));
                if (xfer && sec_last) state_next = LD_B1;
            end
            LD_B1: begin
                sec_last = (cnt == ADDR_W'(N_B1 - 1));
                if (xfer && sec_last) state_next = LD_W2;
            end
            LD_W2: begin
                sec_last = (cnt == ADDR_W'(N_W2 - 1));
                if (xfer && sec_last) state_next = LD_B2;
            end
            LD_B2: begin
                sec_last = (cnt == ADDR_W'(N_B2 - 1));
                if (xfer && sec_last) state_next = LD_IN;
            end
            LD_IN: begin
                sec_last = (cnt == ADDR_W'(N_IN - 1));
                if (xfer && sec_last) state_next = READY;
            end
            READY: begin
                if (load_start)       state_next = start_state;
                else if (mem_release) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= '0;
            wr_data       <= '0;
            wr_addr       <= '0;
            w1_we         <= 1'b0;
            b1_we         <= 1'b0;
            w2_we         <= 1'b0;
            b2_we         <= 1'b0;
            in_we         <= 1'b0;
            weights_valid <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            w1_we    <= 1'b0;
            b1_we    <= 1'b0;
            w2_we    <= 1'b0;
            b2_we    <= 1'b0;
            in_we    <= 1'b0;
            load_err <= load_start && busy;
            if (xfer) begin
                wr_data <= s_data;
                wr_addr <= cnt;
                cnt     <= sec_last ? '0 : cnt + ADDR_W'(1);
                w1_we   <= (state == LD_W1);
                b1_we   <= (state == LD_B1);
                w2_we   <= (state == LD_W2);
                b2_we   <= (state == LD_B2);
                in_we   <= (state == LD_IN);
                if (state == LD_B2 && sec_last) weights_valid <= 1'b1;
            end
        end
    end

endmodule
